uart_buffered_tx: RTL

Parametrised, FIFO-buffered UART transmitter for the serial-bus UART slave path. It replaces a fixed-rate, single-byte transmitter. A bus-side producer pushes words into an internal FIFO. A frame engine serialises each word with runtime-selectable baud divisor, parity mode and stop-bit count. Back-to-back frames are sent with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_buffered_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared types and constants for the buffered UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Mode 2'b11 is a reserved encoding that behaves as "no parity".
    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Purpose  : Show-ahead synchronous FIFO; a push while full is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 16,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_buffered_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_buffered_tx
// Purpose  : FIFO-buffered UART transmitter with per-frame baud divisor,
//            parity mode and stop-bit count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_buffered_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  wrEn,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  count,
    input  logic [DIV_WIDTH-1:0]  baudDiv,
    input  logic [1:0]            parityMode,
    input  logic                  twoStop,
    input  logic                  clearErr,
    output logic                  tx,
    output logic                  busy,
    output logic                  frameDone,
    output logic                  overflow
);

    localparam int               BIT_W    = $clog2(DATA_WIDTH);
    localparam int               FIFO_CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DIV_WIDTH-1:0]  bitcnt_q, bitcnt_d;
    logic [DIV_WIDTH-1:0]  reload_q, reload_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bitidx_q, bitidx_d;
    parity_t               par_q, par_d;
    logic                  two_q, two_d;
    logic                  parbit_q, parbit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic                  w_fifo_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic [FIFO_CW-1:0]    w_fifo_count;
    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_start;
    logic [DIV_WIDTH-1:0]  w_reload_in;
    parity_t               w_par_in;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstN  (rstN),
        .push  (wrEn),
        .pop   (w_fifo_pop),
        .din   (wrData),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign full        = w_fifo_full;
    assign count       = CNT_WIDTH'(w_fifo_count);
    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frameDone   = done_q;
    assign overflow    = ovf_q;

    // A divisor of zero behaves as one clock per bit.
    assign w_reload_in = (baudDiv == '0) ? '0 : baudDiv - 1'b1;
    assign w_par_in    = decode_parity(parityMode);
    assign w_bit_end   = (bitcnt_q == '0);
    assign w_last_stop = two_q ? stop2_q : 1'b1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            reload_q <= '0;
            shift_q  <= '0;
            bitidx_q <= '0;
            par_q    <= PAR_NONE;
            two_q    <= 1'b0;
            parbit_q <= 1'b0;
            stop2_q  <= 1'b0;
            tx_q     <= UART_IDLE_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            reload_q <= reload_d;
            shift_q  <= shift_d;
            bitidx_q <= bitidx_d;
            par_q    <= par_d;
            two_q    <= two_d;
            parbit_q <= parbit_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        reload_d   = reload_q;
        shift_d    = shift_q;
        bitidx_d   = bitidx_q;
        par_d      = par_q;
        two_d      = two_q;
        parbit_d   = parbit_q;
        stop2_d    = stop2_q;
        w_start    = 1'b0;
        w_fifo_pop = 1'b0;

        if (state_q != ST_IDLE) begin
            bitcnt_d = w_bit_end ? reload_q : bitcnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) w_start = 1'b1;
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d  = ST_DATA;
                    bitidx_d = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bitidx_q == LAST_BIT) begin
                        state_d = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                        stop2_d = 1'b0;
                    end else begin
                        bitidx_d = bitidx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    state_d = ST_STOP;
                    stop2_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_last_stop)       stop2_d = 1'b1;
                    else if (!w_fifo_empty) w_start = 1'b1;
                    else                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame start: pop the head and latch this frame's configuration.
        if (w_start) begin
            w_fifo_pop = 1'b1;
            state_d    = ST_START;
            shift_d    = w_fifo_dout;
            reload_d   = w_reload_in;
            bitcnt_d   = w_reload_in;
            par_d      = w_par_in;
            two_d      = twoStop;
            stop2_d    = 1'b0;
            parbit_d   = (^w_fifo_dout) ^ (w_par_in == PAR_ODD);
        end
    end

    // Outputs are registered from next-state values so they align with state_q.
    always_comb begin
        tx_d = UART_IDLE_LEVEL;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parbit_d;
            default:   tx_d = UART_IDLE_LEVEL;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (bitcnt_d == '0) && (two_d ? stop2_d : 1'b1);

        ovf_d = ovf_q;
        if (wrEn && w_fifo_full && !w_fifo_pop) ovf_d = 1'b1;
        else if (clearErr)                      ovf_d = 1'b0;
    end

endmodule
`default_nettype wire
